// File: rtl/step_ctrl_pkg.sv
// ============================================================================
// Module   : step_ctrl_pkg
// Purpose  : Shared state encodings and defaults for the run/step/halt
//            controller and its button conditioners.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package step_ctrl_pkg;

  // Width of the FSM state / mode output
  localparam int MODE_W = 2;

  // FSM state encodings; these double as the externally visible mode code
  localparam logic [MODE_W-1:0] ST_HALT = 2'b00;
  localparam logic [MODE_W-1:0] ST_RUN  = 2'b01;
  localparam logic [MODE_W-1:0] ST_STEP = 2'b10;

  // Debounce length used when the parent does not override it.
  // Simulation-friendly value; a board build overrides with ~1_000_000.
  localparam int DB_CYCLES_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Turns one raw, asynchronous, bouncy push-button into a single
//            clock-wide command pulse per press: 2-flop synchroniser,
//            stable-count debounce, rising-edge-only pulse.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module btn_conditioner
  import step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int DB_W      = 20
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic pulse
);

  // Terminal count: the DB_CYCLES-th consecutive differing sample flips
  // the debounced level.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync_meta;
  logic            sync_out;
  logic            db_level;
  logic [DB_W-1:0] db_cnt;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
    end
  end

  // Debounce: count consecutive samples that disagree with the debounced
  // level; any agreeing sample restarts the count. The pulse is raised in
  // the same edge that flips the level, and only for a 0->1 flip, so a
  // held button or a bouncy release can never generate a second command.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
      pulse    <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync_out != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= sync_out;
          db_cnt   <= '0;
          pulse    <= sync_out;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/step_run_ctrl.sv
// ============================================================================
// Module   : step_run_ctrl
// Purpose  : Run/step/halt controller producing the soft CPU clock enable
//            from three conditioned push-buttons and a breakpoint flag.
//            Also counts enabled cycles for the debug display.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module step_run_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int DB_W      = 20,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              btn_run,
  input  logic              btn_step,
  input  logic              btn_halt,
  input  logic              brk_hit,
  output logic              cpu_en,
  output logic [MODE_W-1:0] mode,
  output logic [CNT_W-1:0]  step_count
);

  logic              run_pulse;
  logic              step_pulse;
  logic              halt_pulse;

  logic [MODE_W-1:0] state;
  logic [MODE_W-1:0] state_nxt;
  logic              run_mask;
  logic              run_mask_nxt;

  // One conditioner per button
  btn_conditioner #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_cond_run (
    .clock  (clock),
    .resetn (resetn),
    .raw    (btn_run),
    .pulse  (run_pulse)
  );

  btn_conditioner #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_cond_step (
    .clock  (clock),
    .resetn (resetn),
    .raw    (btn_step),
    .pulse  (step_pulse)
  );

  btn_conditioner #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_cond_halt (
    .clock  (clock),
    .resetn (resetn),
    .raw    (btn_halt),
    .pulse  (halt_pulse)
  );

  // State and run-mask registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_HALT;
      run_mask <= 1'b0;
    end else begin
      state    <= state_nxt;
      run_mask <= run_mask_nxt;
    end
  end

  // Next-state logic. The run mask is armed on entry to RUN so that a
  // breakpoint still matching at the resume address does not immediately
  // stop the CPU again; it is dropped after the first RUN cycle.
  always_comb begin
    state_nxt    = ST_HALT;
    run_mask_nxt = run_mask;
    case (state)
      ST_HALT: begin
        if (step_pulse) begin
          state_nxt = ST_STEP;
        end else if (run_pulse) begin
          state_nxt    = ST_RUN;
          run_mask_nxt = 1'b1;
        end else begin
          state_nxt = ST_HALT;
        end
      end
      ST_STEP: begin
        state_nxt = ST_HALT;
      end
      ST_RUN: begin
        run_mask_nxt = 1'b0;
        if (halt_pulse || (brk_hit && !run_mask)) begin
          state_nxt = ST_HALT;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_HALT;
      end
    endcase
  end

  // Moore outputs decoded straight from the state register, so the
  // asynchronous reset removes the enable without waiting for a clock.
  always_comb begin
    cpu_en = (state == ST_RUN) || (state == ST_STEP);
    mode   = state;
  end

  // Enabled-cycle counter, free-running modulo 2^CNT_W
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      step_count <= '0;
    end else if (cpu_en) begin
      step_count <= step_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/step_run_ctrl.md
Name: step_run_ctrl

Overview:
Run/step/halt controller that sequences the soft CPU's clock enable from raw board push-buttons and a breakpoint flag.
- Each button is conditioned into a single-cycle command pulse: synchronised, debounced, rising edge only, one pulse per press.
- A 3-state FSM arbitrates those pulses and drives cpu_en.
- Sits between the board I/O wrapper and the CPU core.

Parameters:
DB_CYCLES, 4, consecutive stable synchronised samples required before a debounced level changes (board build uses 1_000_000)
DB_W, 20, debounce counter width; must hold DB_CYCLES
CNT_W, 16, width of step_count

Ports:
clock       in   1      system clock, all logic on rising edge
resetn      in   1      asynchronous, active-low reset
btn_run     in   1      raw run button, asynchronous, bouncy
btn_step    in   1      raw single-step button, asynchronous, bouncy
btn_halt    in   1      raw halt button, asynchronous, bouncy
brk_hit     in   1      synchronous breakpoint-match flag from CPU
cpu_en      out  1      CPU clock enable
mode        out  2      current state: 00 HALT, 01 RUN, 10 STEP
step_count  out  CNT_W  number of cycles with cpu_en=1 since reset

Behaviour:
Reset (resetn=0, asynchronous):
- FSM = HALT, cpu_en=0, mode=00, step_count=0.
- Synchroniser flops, debounced levels and debounce counters all 0.
- Run-mask flag cleared.

Button conditioning (per button):
- 2-flop synchroniser.
- Debounce counter increments while the synchronised level differs from the debounced level. It clears on any sample equal to the debounced level.
- When the counter reaches DB_CYCLES, the debounced level flips and the counter clears.
- Command pulse = debounced 0->1 transition, exactly one cycle wide. No further pulse while the button is held.
- Latency: raw rising edge stable from cycle 0 gives a pulse in cycle 2+DB_CYCLES.
- Release bounce produces no pulse.
- A button held through reset deassertion produces one pulse, DB_CYCLES+2 cycles after deassertion.

FSM (Moore; cpu_en=1 in RUN and STEP, 0 in HALT):
- HALT:
  - step pulse -> STEP.
  - else run pulse -> RUN; set the run-mask flag.
  - halt pulse has no effect.
  - Simultaneous step+run: step wins.
- STEP:
  - -> HALT unconditionally after exactly one cycle.
  - All pulses and brk_hit are ignored.
- RUN:
  - halt pulse -> HALT.
  - brk_hit=1 with run-mask clear -> HALT.
  - brk_hit=1 with run-mask set is ignored. This lets the CPU execute past the breakpoint it stopped on.
  - Run-mask clears after the first RUN cycle.
  - Halt or breakpoint seen in cycle n: cycle n is still enabled, cpu_en=0 from cycle n+1.
  - run and step pulses are ignored.
- Encoding 11 (illegal) -> HALT next cycle, cpu_en=0.

Counter:
- step_count increments by 1 in every cycle with cpu_en=1.
- Wraps modulo 2^CNT_W (all-ones -> 0). No saturation.

Mid-operation reset:
- cpu_en drops immediately (asynchronous).
- No pulse is emitted for a button press that had not yet completed debouncing.

Decomposition:
- Package step_ctrl_pkg:
  - state encodings ST_HALT=2'b00, ST_RUN=2'b01, ST_STEP=2'b10
  - MODE_W=2
  - default DB_CYCLES value
- Sub-module btn_conditioner (clock, resetn, raw, pulse; params DB_CYCLES, DB_W): synchroniser, debounce and edge pulse. Instantiated three times.
- The FSM, run-mask and counter live in the top module.

Test Plan:
1. DB_CYCLES=4; raise btn_step at cycle 0, hold 20 cycles.
   -> step pulse only in cycle 6, cpu_en=1 only in cycle 7, mode=10 in cycle 7, HALT in cycle 8, step_count=1. No second step on release.
2. Toggle btn_run every 2 cycles for 30 cycles, then hold low.
   -> no pulse, mode stays 00, cpu_en=0, step_count=0.
3. Clean run press, let 50 enabled cycles pass, then press halt.
   -> cpu_en falls the cycle after the halt pulse; step_count equals the exact enabled-cycle count (50 + debounce latency).
4. brk_hit held at 1; press run.
   -> cpu_en=1 for exactly 2 cycles (masked first cycle, halt on second), mode back to 00, step_count=2.
5. In HALT, btn_step and btn_run raised on the same cycle.
   -> one STEP cycle, then HALT; run ignored; step_count=1.
6. Run for 65536 enabled cycles with CNT_W=16 -> step_count wraps to 0. Then assert resetn=0 mid-RUN -> cpu_en=0 and mode=00 within the same cycle, no clock edge needed.
